// File: rtl/uart_tx.sv
// uart_tx: UART transmitter framing DBITS data bits (LSB first) between a
// start bit and a stop period of SB_TICK oversample ticks. Bit timing comes
// from the shared 16x s_tick enable.
// Optional even-parity bit: define UART_TX_PARITY_EN to compile it in.
module uart_tx #(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_tick,
  input  logic             tx_start,
  input  logic [DBITS-1:0] tx_din,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done_tick
);

  // Tick counter must cover both the 16-tick bit and the SB_TICK stop period.
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBITS-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic            p_q, p_d;

  // Even parity: XOR of all data bits so the total count of ones is even.
  function automatic logic parity_even(input logic [DBITS-1:0] d);
    return ^d;
  endfunction
`endif

  // State and datapath registers; reset forces the line high at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      p_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      p_q     <= p_d;
`endif
    end
  end

  // Next-state logic; tx is derived from the next state so the pin changes on
  // the same edge the state does (tx falls on the accepting edge).
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    p_d     = p_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // A tick coinciding with acceptance is deliberately not counted.
        if (tx_start) begin
          b_d     = tx_din;
          s_d     = '0;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          p_d     = parity_even(tx_din);
`endif
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            s_d     = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = p_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign tx_busy      = (state_q != ST_IDLE);
  assign tx_done_tick = done_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that frames a parallel byte onto a single line: one start bit, DBITS data bits LSB first, an optional parity bit, and a stop period of SB_TICK oversample ticks. It shares the 16x oversampling tick (s_tick) from the baud-rate generator with the UART receiver. It sits between the transmit FIFO or host logic and the tx pin, using a one-cycle start strobe and a one-cycle done pulse.

## Interface
- DBITS, 8, data bits per frame (1..16)
- SB_TICK, 16, stop-period length in s_tick ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- s_tick  input  1  oversample enable, 16 per bit period, one clk wide
- tx_start  input  1  request to send tx_din; sampled only in idle
- tx_din  input  DBITS  byte to send; captured in the cycle tx_start is accepted
- tx  output  1  serial line, idle high; registered
- tx_busy  output  1  high from acceptance until the tx_done_tick cycle (exclusive)
- tx_done_tick  output  1  one-clk pulse after the stop period completes

## Operation
- State register values: idle, start, data, parity (only with PARITY_EN), stop.
- Datapath registers:
  - s counter: 4 bits, or wide enough for SB_TICK-1.
  - n counter: $clog2(DBITS) bits, minimum 1.
  - b shift register: DBITS bits.
  - tx register.
- idle:
  - tx=1.
  - When tx_start=1, the block:
    - captures tx_din into b
    - clears s
    - goes to start
- start:
  - tx=0.
  - Each s_tick increments s.
  - On the s_tick with s==15, the block clears s and n and goes to data.
- data:
  - tx=b[0].
  - On the s_tick with s==15, the block clears s and shifts b right by 1.
  - If n==DBITS-1, the block goes to parity (PARITY_EN) or stop. Otherwise n increments.
- parity:
  - tx=parity bit, computed as the XOR of tx_din captured at acceptance (even parity).
  - On the s_tick with s==15, the block clears s and goes to stop.
- stop:
  - tx=1.
  - On the s_tick with s==SB_TICK-1, the block returns to idle and sets tx_done_tick for the next cycle.
- Cycles without s_tick hold all state.
- tx_start is ignored outside idle.
- tx_din changes after acceptance have no effect on the frame in flight.
- Illegal state encodings go to idle with tx=1.

## Timing
- Reset values:
  - tx=1
  - tx_busy=0
  - tx_done_tick=0
  - state=idle
  - s, n and b = 0
- Reset asserted mid-frame drives tx high immediately (asynchronously) and abandons the frame. No tx_done_tick is produced.
- Acceptance at edge E: tx falls at E. The value on the tx pin is registered, so there is no combinational path from any input to tx.
- Bit period:
  - 16 s_ticks per start, data and parity bit.
  - SB_TICK s_ticks for the stop period.
- With s_tick tied high and DBITS=8, SB_TICK=16, no parity, tx_start accepted at edge 0:
  - tx=0 for cycles 1–16
  - data bits occupy cycles 17–144
  - tx=1 for stop, cycles 145–160
  - tx_done_tick=1 in cycle 161 with state=idle
- tx_done_tick lasts exactly one clk.
- tx_start asserted in the tx_done_tick cycle is accepted, giving back-to-back frames with no extra idle gap.
- tx_start asserted during stop is dropped, not queued.
- s_tick arriving in the same cycle as acceptance is not counted toward the start bit.

## Configuration
- UART_TX_PARITY_EN defined:
  - The parity state is compiled in.
  - The frame is start + DBITS data + 1 even-parity bit + stop.
  - With s_tick tied high, DBITS=8, SB_TICK=16, the frame is 176 cycles.
- UART_TX_PARITY_EN undefined:
  - No parity state, parity logic or parity bit.
  - The frame is start + data + stop (160 cycles in that configuration).

## Test plan
- Reset, then idle with tx_start=0 for 100 cycles -> tx=1, tx_busy=0, tx_done_tick=0 throughout.
- s_tick every cycle, send 0xA5 -> tx samples at cycles 1, 17, 33, … read 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop). tx_done_tick appears only in cycle 161.
- s_tick every 4th cycle, send 0x00 then 0xFF back-to-back (second tx_start in the done cycle) -> each bit lasts 64 clk, no gap between frames, two tx_done_tick pulses.
- tx_start pulsed with tx_din=0x3C mid-frame during a 0x81 transfer -> 0x81 completes unchanged, 0x3C is never sent, one tx_done_tick.
- Reset asserted at cycle 50 of a frame -> tx=1 immediately, tx_busy=0, no done pulse. A new frame after release sends correctly.
- UART_TX_PARITY_EN defined, send 0x07 -> parity bit =1 in cycles 145–160, stop in cycles 161–176, tx_done_tick in cycle 177.
